// File: rtl/in_port_ctrl.sv
// Input-side I/O controller: show-ahead FIFO feeding the core's in_port, plus
// an edge-detected interrupt held until acked. IN_PORT_IRQ_SYNC_EN adds a 2-flop irq synchronizer.
module in_port_ctrl #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  dev_data,
  input  logic          dev_valid,
  output logic          dev_ready,
  input  logic          in_rd,
  output logic [W-1:0]  in_port,
  output logic          in_valid,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          irq_req,
  input  logic          int_ack,
  output logic          interrupt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wptr, rptr;
  logic          full, empty, push, pop;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dev_ready = !full;
  assign in_valid  = !empty;
  assign count     = wptr - rptr;
  assign push      = dev_valid && dev_ready;
  assign pop       = in_rd && in_valid;
  assign in_port   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= dev_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (dev_valid && full) overflow <= 1'b1;
    end
  end

  logic irq_s, irq_q, rise, pend, pend_nxt;
  irq_state_t state, state_nxt;

`ifdef IN_PORT_IRQ_SYNC_EN
  logic [1:0] irq_sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_sync <= '0;
    else      irq_sync <= {irq_sync[0], irq_req};
  end
  assign irq_s = irq_sync[1];
`else
  assign irq_s = irq_req;
`endif

  assign rise = irq_s && !irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pend  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      irq_q <= irq_s;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    interrupt = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = REQ;
      REQ: begin
        interrupt = 1'b1;
        // A rise coinciding with the ack still counts as pending.
        if (rise) pend_nxt = 1'b1;
        if (int_ack) state_nxt = (pend || rise) ? GAP : IDLE;
      end
      GAP: begin
        pend_nxt  = 1'b0;
        state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_in_port_ctrl.sv
// Directed bench for in_port_ctrl: FIFO vector table, pointer wrap, interrupt
// pend/gap sequence and asynchronous reset.
module tb_in_port_ctrl;
  localparam int W = 16, DEPTH = 4, CW = 3;
`ifdef IN_PORT_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  dev_data;
  logic          dev_valid, dev_ready, in_rd, in_valid, overflow;
  logic [W-1:0]  in_port;
  logic [CW-1:0] count;
  logic          irq_req, int_ack, interrupt;

  int checks = 0, failures = 0;

  in_port_ctrl #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .dev_data(dev_data), .dev_valid(dev_valid),
    .dev_ready(dev_ready), .in_rd(in_rd), .in_port(in_port), .in_valid(in_valid),
    .count(count), .overflow(overflow), .irq_req(irq_req), .int_ack(int_ack),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         dv;
    logic [W-1:0] dd;
    logic         rd;
    logic [W-1:0] e_port;
    logic         e_valid;
    logic [CW-1:0] e_count;
    logic         e_ready;
    logic         e_ovf;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic irq_steps(input int n, input logic exp, input string name);
    for (int k = 0; k < n; k++) begin
      step();
      chk(name, {31'b0, interrupt}, {31'b0, exp});
    end
  endtask

  initial begin
    vecs[0]  = '{1, 16'h1111, 0, 16'h1111, 1, 1, 1, 0};
    vecs[1]  = '{1, 16'h2222, 0, 16'h1111, 1, 2, 1, 0};
    vecs[2]  = '{1, 16'h3333, 0, 16'h1111, 1, 3, 1, 0};
    vecs[3]  = '{0, 16'h0000, 1, 16'h2222, 1, 2, 1, 0};
    vecs[4]  = '{0, 16'h0000, 1, 16'h3333, 1, 1, 1, 0};
    vecs[5]  = '{0, 16'h0000, 1, 16'h0000, 0, 0, 1, 0};
    vecs[6]  = '{0, 16'h0000, 1, 16'h0000, 0, 0, 1, 0};  // read while empty
    vecs[7]  = '{1, 16'hAAAA, 1, 16'hAAAA, 1, 1, 1, 0};  // empty: push only
    vecs[8]  = '{1, 16'hBBBB, 0, 16'hAAAA, 1, 2, 1, 0};
    vecs[9]  = '{1, 16'hABCD, 1, 16'hBBBB, 1, 2, 1, 0};  // push+pop
    vecs[10] = '{1, 16'hC001, 0, 16'hBBBB, 1, 3, 1, 0};
    vecs[11] = '{1, 16'hC002, 0, 16'hBBBB, 1, 4, 0, 0};
    vecs[12] = '{1, 16'hC003, 0, 16'hBBBB, 1, 4, 0, 1};  // offered while full
    vecs[13] = '{1, 16'hC003, 1, 16'hABCD, 1, 3, 1, 1};  // pop only while full
    vecs[14] = '{1, 16'hC003, 0, 16'hABCD, 1, 4, 0, 1};
    vecs[15] = '{0, 16'h0000, 1, 16'hC001, 1, 3, 1, 1};
    vecs[16] = '{0, 16'h0000, 1, 16'hC002, 1, 2, 1, 1};
    vecs[17] = '{0, 16'h0000, 1, 16'hC003, 1, 1, 1, 1};
    vecs[18] = '{0, 16'h0000, 1, 16'h0000, 0, 0, 1, 1};

    dev_data = '0; dev_valid = 0; in_rd = 0; irq_req = 0; int_ack = 0;
    do_reset();
    chk("rst_ready", {31'b0, dev_ready}, 1);
    chk("rst_valid", {31'b0, in_valid}, 0);
    chk("rst_port", {16'b0, in_port}, 0);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_int", {31'b0, interrupt}, 0);

    foreach (vecs[i]) begin
      dev_valid = vecs[i].dv; dev_data = vecs[i].dd; in_rd = vecs[i].rd;
      step();
      chk($sformatf("v%0d_port", i), {16'b0, in_port}, {16'b0, vecs[i].e_port});
      chk($sformatf("v%0d_valid", i), {31'b0, in_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_count", i), {29'b0, count}, {29'b0, vecs[i].e_count});
      chk($sformatf("v%0d_ready", i), {31'b0, dev_ready}, {31'b0, vecs[i].e_ready});
      chk($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].e_ovf});
    end
    dev_valid = 0; in_rd = 0;

    // Pointer wrap: streaming push/pop of 0..9 through a 4-deep FIFO.
    dev_valid = 1; dev_data = 16'h0000;
    step();
    for (int i = 1; i < 10; i++) begin
      dev_data = W'(i); in_rd = 1;
      step();
      chk($sformatf("wrap%0d_port", i), {16'b0, in_port}, i);
      chk($sformatf("wrap%0d_count", i), {29'b0, count}, 1);
    end
    dev_valid = 0; in_rd = 1;
    step();
    in_rd = 0;
    chk("wrap_empty", {31'b0, in_valid}, 0);

    // Interrupt: rise, second rise pended, ack -> gap -> req, ack -> idle.
    do_reset();
    chk("ovf_cleared", {31'b0, overflow}, 0);
    irq_req = 1;
    irq_steps(LAT - 1, 1'b0, "irq_lat_low");
    irq_steps(1, 1'b1, "irq_assert");
    irq_req = 0;
    irq_steps(LAT + 1, 1'b1, "irq_hold_low");
    irq_req = 1;
    irq_steps(LAT + 1, 1'b1, "irq_hold_pend");
    int_ack = 1;
    step();
    int_ack = 0;
    chk("irq_gap", {31'b0, interrupt}, 0);
    irq_steps(1, 1'b1, "irq_reassert");
    irq_steps(2, 1'b1, "irq_wait_ack");
    int_ack = 1;
    step();
    int_ack = 0;
    chk("irq_ack_idle", {31'b0, interrupt}, 0);
    int_ack = 1;  // ack in IDLE is ignored
    irq_steps(3, 1'b0, "irq_stay_idle");
    int_ack = 0;

    // Async reset mid-cycle with interrupt high and count 3.
    irq_req = 0;
    irq_steps(LAT + 1, 1'b0, "irq_pre_low");
    dev_valid = 1; dev_data = 16'h5555; irq_req = 1;
    step(); step(); step();
    dev_valid = 0;
    irq_steps(LAT, 1'b1, "pre_rst_int");
    chk("pre_rst_count", {29'b0, count}, 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_int", {31'b0, interrupt}, 0);
    chk("arst_count", {29'b0, count}, 0);
    chk("arst_valid", {31'b0, in_valid}, 0);
    chk("arst_port", {16'b0, in_port}, 0);
    irq_req = 0;
    step();
    rst = 1'b1;
    step();
    chk("post_rst_int", {31'b0, interrupt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
